j_uart_host: RTL and testbench

J_UART_HOST -- requirements
Module: j_uart_host

---
 rtl/j_uart_host.sv | 169 ++++++++++++++++
 tb/tb_j_uart_host.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j_uart_host.sv
// Host-side poller for a 16-bit register-mapped UART: reads status, then moves one
// byte between the UART and a local TX/RX FIFO pair per poll cycle.
module j_uart_host #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic        enable,
  input  logic        tx_wr,
  input  logic [7:0]  tx_data,
  output logic        tx_full,
  input  logic        rx_rd,
  output logic [7:0]  rx_data,
  output logic        rx_empty,
  output logic        rx_ovf,
  output logic        err,
  input  logic        flag_clr,
  output logic        u2strd,
  output logic        u2drd,
  output logic        u2dwr,
  input  logic [15:0] u_rdata,
  output logic [15:0] u_wdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_EVAL,
    S_RD,
    S_WR,
    S_GAP
  } state_e;

  state_e      state_q;
  logic [15:0] stat_q;
  logic        rdy_q;
  logic        err_q;
  logic        ovf_q;
  logic        u2strd_q;
  logic        u2drd_q;
  logic        u2dwr_q;
  logic [15:0] u_wdata_q;

  logic [7:0]    tx_mem_q [DEPTH];
  logic [PW-1:0] tx_wp_q;
  logic [PW-1:0] tx_rp_q;
  logic [CW-1:0] tx_cnt_q;
  logic [CW-1:0] tx_cnt_d;
  logic          tx_push;
  logic          tx_pop;

  logic [7:0]    rx_mem_q [DEPTH];
  logic [PW-1:0] rx_wp_q;
  logic [PW-1:0] rx_rp_q;
  logic [CW-1:0] rx_cnt_q;
  logic [CW-1:0] rx_cnt_d;
  logic          rx_full;
  logic          rx_push;
  logic          rx_pop;

  logic          err_set;
  logic          ovf_set;
  logic          stat_unused;

  assign stat_unused = ^stat_q[14:2];

  // Full is judged on the pre-pop count, so a push racing a WR pop is still refused.
  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign tx_push  = tx_wr && !tx_full;
  assign tx_pop   = (state_q == S_WR);
  assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);

  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_push  = (state_q == S_RD) && !rx_full;
  assign rx_pop   = rx_rd && !rx_empty;
  assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  assign rx_data  = rx_mem_q[rx_rp_q];

  assign err_set  = (state_q == S_EVAL) && stat_q[15];
  assign ovf_set  = (state_q == S_RD) && rx_full;

  assign err      = err_q;
  assign rx_ovf   = ovf_q;
  assign u2strd   = u2strd_q;
  assign u2drd    = u2drd_q;
  assign u2dwr    = u2dwr_q;
  assign u_wdata  = u_wdata_q;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + PW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + PW'(1);
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= tx_data;
    if (rx_push) rx_mem_q[rx_wp_q] <= u_rdata[7:0];
  end

  // Strobes and u_wdata are registered from the state being entered, so each is
  // high exactly for the cycle the FSM spends in POLL, RD or WR.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q   <= S_IDLE;
      stat_q    <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      u2strd_q  <= 1'b0;
      u2drd_q   <= 1'b0;
      u2dwr_q   <= 1'b0;
      u_wdata_q <= '0;
    end else begin
      u2strd_q  <= 1'b0;
      u2drd_q   <= 1'b0;
      u2dwr_q   <= 1'b0;
      u_wdata_q <= '0;
      rdy_q     <= rdy_q | enable;
      err_q     <= err_set | (err_q & ~flag_clr);
      ovf_q     <= ovf_set | (ovf_q & ~flag_clr);
      case (state_q)
        S_IDLE: begin
          // rdy_q holds off the first poll until a second enabled edge after reset.
          if (enable && rdy_q) begin
            state_q  <= S_POLL;
            u2strd_q <= 1'b1;
          end
        end
        S_POLL: begin
          stat_q  <= u_rdata;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          if (stat_q[0]) begin
            state_q <= S_RD;
            u2drd_q <= 1'b1;
          end else if (stat_q[1] && (tx_cnt_q != '0)) begin
            state_q   <= S_WR;
            u2dwr_q   <= 1'b1;
            u_wdata_q <= {8'h00, tx_mem_q[tx_rp_q]};
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD:    state_q <= S_GAP;
        S_WR:    state_q <= S_GAP;
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_j_uart_host.sv
// Bench for j_uart_host: directed scenarios plus a randomized phase, all checked
// against a queue-based model of the FIFOs, flags and poll protocol.
module tb_j_uart_host;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetl;
  logic        enable;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic        tx_full;
  logic        rx_rd;
  logic [7:0]  rx_data;
  logic        rx_empty;
  logic        rx_ovf;
  logic        err;
  logic        flag_clr;
  logic        u2strd;
  logic        u2drd;
  logic        u2dwr;
  logic [15:0] u_rdata;
  logic [15:0] u_wdata;

  logic [15:0] stat_resp;
  logic [7:0]  rx_byte_resp;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         exp_ovf;
  bit         exp_err;
  int         cyc;
  int         poll_cyc;
  logic [15:0] poll_stat;
  int         exp_kind;
  bit         last_xfer;
  int         n_wr;

  j_uart_host #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetl(resetl), .enable(enable),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_ovf(rx_ovf), .err(err), .flag_clr(flag_clr),
    .u2strd(u2strd), .u2drd(u2drd), .u2dwr(u2dwr),
    .u_rdata(u_rdata), .u_wdata(u_wdata)
  );

  always #5 clk = ~clk;

  // UART device model: status on a status read, data byte on a data read.
  assign u_rdata = u2strd ? stat_resp : (u2drd ? {8'h00, rx_byte_resp} : 16'h0000);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: checks the current cycle, then applies the effects of the next edge.
  always @(negedge clk) begin
    if (!resetl) begin
      tx_q.delete();
      rx_q.delete();
      exp_ovf   = 1'b0;
      exp_err   = 1'b0;
      poll_cyc  = -100;
      exp_kind  = 0;
      last_xfer = 1'b0;
    end else begin
      bit tx_full_pre, rx_full_pre, err_set, ovf_set;
      cyc++;
      chk("strobe_onehot", 32'($countones({u2strd, u2drd, u2dwr}) <= 1), 1);
      if (!u2dwr) chk("wdata_idle", u_wdata, 16'h0000);
      chk("tx_full", tx_full, tx_q.size() == DEPTH);
      chk("rx_empty", rx_empty, rx_q.size() == 0);
      if (rx_q.size() > 0) chk("rx_data", rx_data, rx_q[0]);
      chk("rx_ovf", rx_ovf, exp_ovf);
      chk("err", err, exp_err);

      if (cyc == poll_cyc + 1) begin
        chk("eval_quiet", {u2strd, u2drd, u2dwr}, 3'b000);
        exp_kind = poll_stat[0] ? 1 : ((poll_stat[1] && tx_q.size() > 0) ? 2 : 0);
      end else if (cyc == poll_cyc + 2) begin
        chk("rd_strobe", u2drd, exp_kind == 1);
        chk("wr_strobe", u2dwr, exp_kind == 2);
        last_xfer = (exp_kind != 0);
      end else begin
        chk("stray_data_strobe", {u2drd, u2dwr}, 2'b00);
      end
      if (u2strd) begin
        chk("poll_spacing", 32'((cyc - poll_cyc) >= (last_xfer ? 4 : 3)), 1);
        poll_cyc  = cyc;
        poll_stat = u_rdata;
        last_xfer = 1'b0;
      end
      if (u2dwr) begin
        n_wr++;
        if (tx_q.size() > 0) chk("wdata", u_wdata, {8'h00, tx_q[0]});
      end

      tx_full_pre = (tx_q.size() == DEPTH);
      rx_full_pre = (rx_q.size() == DEPTH);
      err_set = (cyc == poll_cyc + 1) && poll_stat[15];
      ovf_set = u2drd && rx_full_pre;
      if (u2dwr && tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_wr && !tx_full_pre) tx_q.push_back(tx_data);
      if (rx_rd && rx_q.size() > 0) void'(rx_q.pop_front());
      if (u2drd && !rx_full_pre) rx_q.push_back(u_rdata[7:0]);
      exp_err = err_set | (exp_err & !flag_clr);
      exp_ovf = ovf_set | (exp_ovf & !flag_clr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    enable = 1'b0;
    repeat (6) step();
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr = 1'b1;
    tx_data = b;
    step();
    tx_wr = 1'b0;
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    step();
  endtask

  task automatic wait_sig(input int which, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((which == 0 && u2strd) || (which == 1 && u2drd) || (which == 2 && u2dwr)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit got;
    int n0;
    logic [7:0] b;
    logic [7:0] sent [5];
    logic [7:0] tb_bytes [4];
    logic [15:0] stat_tbl [6];
    stat_tbl = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h8000, 16'h8003};
    cyc = 0; poll_cyc = -100; n_wr = 0;
    resetl = 1'b1; enable = 1'b0; tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0;
    flag_clr = 1'b0; stat_resp = 16'h0000; rx_byte_resp = 8'h00;
    #2 resetl = 1'b0;
    #1;
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_rx_empty", rx_empty, 1'b1);
    chk("rst_flags", {rx_ovf, err}, 2'b00);
    chk("rst_strobes", {u2strd, u2drd, u2dwr}, 3'b000);
    chk("rst_wdata", u_wdata, 16'h0000);
    repeat (2) @(posedge clk);
    #1 resetl = 1'b1;
    step();

    // Single TX byte written after a status of "tx empty".
    push_tx(8'hA5);
    n0 = n_wr;
    stat_resp = 16'h0002;
    enable = 1'b1;
    wait_sig(0, 10, got); chk("a5_poll", got, 1);
    wait_sig(2, 10, got); chk("a5_write", got, 1);
    chk("a5_wdata", u_wdata, 16'h00A5);
    repeat (12) step();
    chk("a5_single_write", n_wr - n0, 1);
    settle();

    // RX takes priority over a pending TX byte.
    b = 8'($urandom);
    push_tx(b);
    stat_resp = 16'h0003;
    rx_byte_resp = 8'h42;
    enable = 1'b1;
    wait_sig(1, 10, got); chk("prio_rd", got, 1);
    chk("prio_no_wr", u2dwr, 1'b0);
    stat_resp = 16'h0002;
    step();
    chk("prio_rx_data", rx_data, 8'h42);
    chk("prio_rx_nonempty", rx_empty, 1'b0);
    wait_sig(2, 10, got); chk("prio_wr_next", got, 1);
    chk("prio_wdata", u_wdata, {8'h00, b});
    settle();
    rx_rd = 1'b1; step(); rx_rd = 1'b0;
    chk("prio_rx_drained", rx_empty, 1'b1);

    // Randomized traffic with overlapping pushes, pops, clears and status values.
    for (int i = 0; i < 400; i++) begin
      enable       = ($urandom_range(0, 3) != 0);
      tx_wr        = ($urandom_range(0, 2) == 0);
      tx_data      = 8'($urandom);
      rx_rd        = ($urandom_range(0, 2) == 0);
      flag_clr     = ($urandom_range(0, 7) == 0);
      stat_resp    = stat_tbl[$urandom_range(0, 5)];
      rx_byte_resp = 8'($urandom);
      step();
    end
    tx_wr = 1'b0; rx_rd = 1'b0; flag_clr = 1'b0;
    settle();

    // RX overflow: five reads into a four-entry FIFO.
    rx_rd = 1'b1;
    for (int i = 0; i < 2 * DEPTH && !rx_empty; i++) step();
    rx_rd = 1'b0;
    pulse_clr();
    chk("ovf_pre_clear", rx_ovf, 1'b0);
    stat_resp = 16'h0001;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sent[i] = 8'($urandom);
      rx_byte_resp = sent[i];
      wait_sig(1, 12, got); chk("ovf_rd", got, 1);
      step();
    end
    enable = 1'b0;
    settle();
    chk("ovf_set", rx_ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", rx_data, sent[i]);
      rx_rd = 1'b1; step(); rx_rd = 1'b0;
    end
    chk("ovf_fifth_dropped", rx_empty, 1'b1);
    pulse_clr();
    chk("ovf_cleared", rx_ovf, 1'b0);

    // TX full: a push during the WR pop is refused; order survives pointer wrap.
    stat_resp = 16'h0002;
    enable = 1'b1;
    for (int i = 0; i < 60 && tx_q.size() > 0; i++) step();
    settle();
    for (int i = 0; i < 4; i++) begin
      tb_bytes[i] = 8'($urandom);
      push_tx(tb_bytes[i]);
    end
    chk("txf_full", tx_full, 1'b1);
    enable = 1'b1;
    wait_sig(2, 12, got); chk("txf_wr", got, 1);
    chk("txf_wdata0", u_wdata, {8'h00, tb_bytes[0]});
    tx_wr = 1'b1; tx_data = 8'($urandom); enable = 1'b0;
    step();
    tx_wr = 1'b0;
    settle();
    chk("txf_not_full", tx_full, 1'b0);
    enable = 1'b1;
    for (int i = 1; i < 4; i++) begin
      wait_sig(2, 12, got); chk("txf_drain", got, 1);
      chk("txf_order", u_wdata, {8'h00, tb_bytes[i]});
    end
    wait_sig(2, 12, got); chk("txf_fifth_rejected", got, 0);
    settle();

    // Error status: sticky err, no data strobe.
    pulse_clr();
    chk("err_pre_clear", err, 1'b0);
    stat_resp = 16'h8000;
    enable = 1'b1;
    wait_sig(0, 10, got); chk("err_poll", got, 1);
    step();
    step();
    chk("err_no_data_strobe", {u2drd, u2dwr}, 2'b00);
    chk("err_set", err, 1'b1);
    settle();
    chk("err_sticky", err, 1'b1);
    pulse_clr();
    chk("err_cleared", err, 1'b0);

    // Reset during RD aborts everything; first poll needs two enabled edges.
    push_tx(8'($urandom));
    stat_resp = 16'h0001;
    rx_byte_resp = 8'($urandom);
    enable = 1'b1;
    wait_sig(1, 10, got); chk("rst_rd", got, 1);
    #1 resetl = 1'b0;
    #1;
    chk("rst_rd_strobe", {u2strd, u2drd, u2dwr}, 3'b000);
    chk("rst_rd_rx_empty", rx_empty, 1'b1);
    chk("rst_rd_tx_full", tx_full, 1'b0);
    chk("rst_rd_wdata", u_wdata, 16'h0000);
    enable = 1'b0;
    step(); step();
    stat_resp = 16'h0002;
    enable = 1'b1;
    resetl = 1'b1;
    step();
    chk("first_poll_early", u2strd, 1'b0);
    wait_sig(0, 6, got); chk("first_poll", got, 1);
    wait_sig(2, 12, got); chk("rst_tx_discarded", got, 0);
    chk("rst_rx_discarded", rx_empty, 1'b1);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
